// File: rtl/display_mux_decoder_if.sv
// Display bus for display_mux_decoder: value load handshake, ring-counter scan inputs,
// and the registered segment/anode outputs.
interface display_mux_decoder_if;
  logic [15:0] data;
  logic [3:0]  dp;
  logic        load;
  logic        busy;
  logic [1:0]  sel;
  logic [3:0]  anodo;
  logic [6:0]  seg;
  logic        seg_dp;
  logic [3:0]  an;
  logic        err;

  modport master (
    output data, dp, load, sel, anodo,
    input  busy, seg, seg_dp, an, err
  );

  modport slave (
    input  data, dp, load, sel, anodo,
    output busy, seg, seg_dp, an, err
  );
endinterface

// File: rtl/display_mux_decoder.sv
// Double-buffered 4-digit hex display decoder; swaps values only at frame boundaries.
// Optional build macro LEADING_ZERO_BLANK_EN blanks digits above the top nonzero nibble.
module display_mux_decoder #(
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit AN_ACTIVE_LOW  = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  display_mux_decoder_if.slave  bus
);

  localparam logic [6:0] SEG_OFF = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic       DP_OFF  = SEG_ACTIVE_LOW;
  localparam logic [3:0] AN_OFF  = AN_ACTIVE_LOW ? 4'hF : 4'h0;

  logic [15:0] act_data;
  logic [3:0]  act_dp;
  logic [15:0] pend_data;
  logic [3:0]  pend_dp;
  logic        pend;

  logic        boundary;
  logic [3:0]  sel_onehot;
  logic        anode_bad;
  logic [3:0]  nibble;
  logic        blank;
  logic [6:0]  seg_raw;
  logic [6:0]  seg_next;
  logic        dp_next;
  logic [3:0]  an_next;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] hex);
    logic [6:0] s;
    case (hex)
      4'h0: s = 7'h3F;
      4'h1: s = 7'h06;
      4'h2: s = 7'h5B;
      4'h3: s = 7'h4F;
      4'h4: s = 7'h66;
      4'h5: s = 7'h6D;
      4'h6: s = 7'h7D;
      4'h7: s = 7'h07;
      4'h8: s = 7'h7F;
      4'h9: s = 7'h6F;
      4'hA: s = 7'h77;
      4'hB: s = 7'h7C;
      4'hC: s = 7'h39;
      4'hD: s = 7'h5E;
      4'hE: s = 7'h79;
      default: s = 7'h71;
    endcase
    return s;
  endfunction

  assign boundary   = (bus.sel == 2'd3);
  assign sel_onehot = 4'b0001 << bus.sel;
  assign anode_bad  = (bus.anodo != sel_onehot);
  assign nibble     = act_data[{bus.sel, 2'b00} +: 4];
  assign seg_raw    = hex_to_seg(nibble);

`ifdef LEADING_ZERO_BLANK_EN
  // A digit is blank when it and every digit above it are zero; digit 0 always shows.
  always_comb begin
    blank = 1'b0;
    case (bus.sel)
      2'd1: blank = (act_data[15:4] == 12'h000);
      2'd2: blank = (act_data[15:8] == 8'h00);
      2'd3: blank = (act_data[15:12] == 4'h0);
      default: blank = 1'b0;
    endcase
  end
`else
  assign blank = 1'b0;
`endif

  always_comb begin
    seg_next = blank ? SEG_OFF : (seg_raw ^ {7{SEG_ACTIVE_LOW}});
    dp_next  = act_dp[bus.sel] ^ SEG_ACTIVE_LOW;
    an_next  = anode_bad ? AN_OFF : (sel_onehot ^ {4{AN_ACTIVE_LOW}});
  end

  // Load/swap: a load at the boundary goes straight to the shown value and drops any pending one.
  always_ff @(posedge clk) begin
    if (rst) begin
      act_data  <= 16'h0000;
      act_dp    <= 4'h0;
      pend_data <= 16'h0000;
      pend_dp   <= 4'h0;
      pend      <= 1'b0;
    end else if (boundary) begin
      if (bus.load) begin
        act_data <= bus.data;
        act_dp   <= bus.dp;
        pend     <= 1'b0;
      end else if (pend) begin
        act_data <= pend_data;
        act_dp   <= pend_dp;
        pend     <= 1'b0;
      end
    end else if (bus.load) begin
      pend_data <= bus.data;
      pend_dp   <= bus.dp;
      pend      <= 1'b1;
    end
  end

  // Output stage uses act as it was this cycle, so a boundary swap shows from the next digit 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.seg    <= SEG_OFF;
      bus.seg_dp <= DP_OFF;
      bus.an     <= AN_OFF;
      bus.err    <= 1'b0;
    end else begin
      bus.seg    <= seg_next;
      bus.seg_dp <= dp_next;
      bus.an     <= an_next;
      if (anode_bad) begin
        bus.err <= 1'b1;
      end
    end
  end

  assign bus.busy = pend;

endmodule

// File: tb/tb_display_mux_decoder.sv
// Bench for display_mux_decoder: value-level display model plus directed frame scenarios.
module tb_display_mux_decoder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic chk_en = 1'b0;
  always #5 clk = ~clk;

  display_mux_decoder_if bus();

  display_mux_decoder #(
    .SEG_ACTIVE_LOW(1'b1),
    .AN_ACTIVE_LOW (1'b0)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int vectors = 0;
  int miscompares = 0;

  logic [6:0]  hex_segs [16];
  logic [15:0] m_shown_val, m_queued_val;
  logic [3:0]  m_shown_dp, m_queued_dp;
  logic        m_queued;
  logic [6:0]  exp_seg;
  logic        exp_dp;
  logic [3:0]  exp_an;
  logic        exp_err;
  logic [15:0] upper;
  logic        blank_m;
  int          s_m;

  task automatic chk(input string name, input logic [15:0] got, input logic [15:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, got, want);
    end
  endtask

  // Model: what a common-anode display must show given the value in view and the queued one.
  always @(posedge clk) begin
    if (rst) begin
      m_shown_val = 16'h0; m_shown_dp = 4'h0;
      m_queued_val = 16'h0; m_queued_dp = 4'h0; m_queued = 1'b0;
      exp_seg = 7'h7F; exp_dp = 1'b1; exp_an = 4'b0000; exp_err = 1'b0;
    end else begin
      s_m = int'(bus.sel);
      upper = m_shown_val >> (4 * s_m);
      blank_m = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
      blank_m = (s_m != 0) && (upper == 16'h0);
`endif
      exp_seg = blank_m ? 7'h7F : ~hex_segs[upper[3:0]];
      exp_dp  = ~m_shown_dp[s_m];
      if (bus.anodo == (4'b0001 << s_m)) exp_an = 4'b0001 << s_m;
      else begin
        exp_an  = 4'b0000;
        exp_err = 1'b1;
      end
      if (s_m == 3) begin
        if (bus.load) begin
          m_shown_val = bus.data; m_shown_dp = bus.dp;
        end else if (m_queued) begin
          m_shown_val = m_queued_val; m_shown_dp = m_queued_dp;
        end
        m_queued = 1'b0;
      end else if (bus.load) begin
        m_queued_val = bus.data; m_queued_dp = bus.dp; m_queued = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("seg", {9'h0, bus.seg}, {9'h0, exp_seg});
      chk("dp", {15'h0, bus.seg_dp}, {15'h0, exp_dp});
      chk("an", {12'h0, bus.an}, {12'h0, exp_an});
      chk("busy", {15'h0, bus.busy}, {15'h0, m_queued});
      chk("err", {15'h0, bus.err}, {15'h0, exp_err});
    end
  end

  task automatic step(input logic [1:0] s, input logic [3:0] an, input logic ld,
                      input logic [15:0] d, input logic [3:0] p);
    bus.sel = s; bus.anodo = an; bus.load = ld; bus.data = d; bus.dp = p;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic scan(input logic [1:0] s);
    step(s, 4'b0001 << s, 1'b0, 16'h0, 4'h0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    scan(2'd0);
    rst = 1'b0;
  endtask

  initial begin
    hex_segs = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    bus.sel = 2'd0; bus.anodo = 4'b0001; bus.load = 1'b0; bus.data = 16'h0; bus.dp = 4'h0;
    chk_en = 1'b1;

    do_reset();
    chk("rst_seg", {9'h0, bus.seg}, 16'h007F);
    chk("rst_dp", {15'h0, bus.seg_dp}, 16'h0001);
    chk("rst_an", {12'h0, bus.an}, 16'h0000);
    chk("rst_busy", {15'h0, bus.busy}, 16'h0000);
    chk("rst_err", {15'h0, bus.err}, 16'h0000);

    // Load mid-frame waits for the boundary
    step(2'd1, 4'b0010, 1'b1, 16'h1234, 4'b0001);
    chk("t2_busy1", {15'h0, bus.busy}, 16'h0001);
    scan(2'd2);
    chk("t2_busy2", {15'h0, bus.busy}, 16'h0001);
    scan(2'd3);
    chk("t2_busy3", {15'h0, bus.busy}, 16'h0000);
    scan(2'd0);
    chk("t2_seg_d0", {9'h0, bus.seg}, 16'h0019);
    chk("t2_an_d0", {12'h0, bus.an}, 16'h0001);
    chk("t2_dp_d0", {15'h0, bus.seg_dp}, 16'h0000);
    scan(2'd1);
    chk("t2_seg_d1", {9'h0, bus.seg}, 16'h0030);
    scan(2'd2);
    scan(2'd3);

    // Newest pending value wins
    step(2'd0, 4'b0001, 1'b1, 16'hAAAA, 4'h0);
    step(2'd1, 4'b0010, 1'b1, 16'h5555, 4'h0);
    scan(2'd2);
    scan(2'd3);
    for (int k = 0; k < 4; k++) begin
      scan(k[1:0]);
      chk("t3_seg5", {9'h0, bus.seg}, 16'h0012);
    end

    // Boundary load overrides pending
    step(2'd0, 4'b0001, 1'b1, 16'h1111, 4'h0);
    chk("t4_busy", {15'h0, bus.busy}, 16'h0001);
    scan(2'd1);
    scan(2'd2);
    step(2'd3, 4'b1000, 1'b1, 16'h2222, 4'h0);
    chk("t4_busy_clr", {15'h0, bus.busy}, 16'h0000);
    for (int k = 0; k < 4; k++) begin
      scan(k[1:0]);
      chk("t4_seg2", {9'h0, bus.seg}, 16'h0024);
    end

    // Reset mid-load discards pending value
    step(2'd0, 4'b0001, 1'b1, 16'h9999, 4'h0);
    rst = 1'b1;
    scan(2'd1);
    rst = 1'b0;
    chk("rst_mid_busy", {15'h0, bus.busy}, 16'h0000);
    scan(2'd2);
    scan(2'd3);
    scan(2'd0);
    chk("rst_mid_seg0", {9'h0, bus.seg}, 16'h0040);
    scan(2'd1);
    scan(2'd2);
    scan(2'd3);

    // Anode inconsistency is sticky
    step(2'd0, 4'b0011, 1'b0, 16'h0, 4'h0);
    chk("t5_err", {15'h0, bus.err}, 16'h0001);
    chk("t5_an_off", {12'h0, bus.an}, 16'h0000);
    for (int k = 1; k < 5; k++) scan(k[1:0]);
    chk("t5_err_held", {15'h0, bus.err}, 16'h0001);
    chk("t5_an_back", {12'h0, bus.an}, 16'h0001);
    do_reset();
    chk("t5_err_clr", {15'h0, bus.err}, 16'h0000);

    // Leading-zero handling for 0x0042
    step(2'd3, 4'b1000, 1'b1, 16'h0042, 4'h0);
    scan(2'd0);
    chk("t6_d0", {9'h0, bus.seg}, 16'h0024);
    scan(2'd1);
    chk("t6_d1", {9'h0, bus.seg}, 16'h0019);
`ifdef LEADING_ZERO_BLANK_EN
    scan(2'd2);
    chk("t6_d2", {9'h0, bus.seg}, 16'h007F);
    scan(2'd3);
    chk("t6_d3", {9'h0, bus.seg}, 16'h007F);
`else
    scan(2'd2);
    chk("t6_d2", {9'h0, bus.seg}, 16'h0040);
    scan(2'd3);
    chk("t6_d3", {9'h0, bus.seg}, 16'h0040);
`endif

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
